// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with runtime almost-full/empty
// thresholds and sticky overflow/underflow; FWFT via SYNC_FIFO_FWFT_EN.
//
// Ports:
//   clk, rst_n (async, active-low)
//   wr_en, wr_data     : push side
//   rd_en, rd_data     : pop side (rd_en pops the head in FWFT mode)
//   valid_rd           : standard - one-cycle pulse after an accepted read
//                        FWFT     - !fifo_empty
//   fifo_full, fifo_empty, almost_full, almost_empty, fifo_count
//   af_thresh, ae_thresh : live threshold inputs
//   overflow, underflow  : sticky error flags, cleared by err_clr
//
// `define SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  valid_rd,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] FULL_CNT =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic                wa;
  logic                ra;

  assign wa = wr_en && !fifo_full;
  assign ra = rd_en && !fifo_empty;

  assign fifo_count   = count;
  assign fifo_full    = (count == FULL_CNT);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + ONE;
      if (ra) rd_ptr <= rd_ptr + ONE;
      unique case (1'b1)
        (wa && !ra): count <= count + ONE;
        (ra && !wa): count <= count - ONE;
        default:     count <= count;
      endcase
    end
  end

  // Setting has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (err_clr)       overflow <= 1'b0;
      if (rd_en && fifo_empty) underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN

  // rd_data always mirrors mem[rd_ptr]; the word count includes it.
  logic [ADDR_WIDTH:0] rd_ptr_nxt;
  logic [ADDR_WIDTH:0] count_nxt;
  logic                head_load;

  always_comb begin
    rd_ptr_nxt = ra ? rd_ptr + ONE : rd_ptr;
    count_nxt  = count;
    unique case (1'b1)
      (wa && !ra): count_nxt = count + ONE;
      (ra && !wa): count_nxt = count - ONE;
      default:     count_nxt = count;
    endcase
    head_load = (ra || fifo_empty) && (count_nxt != '0);
  end

  assign valid_rd = !fifo_empty;

  // When the new head is the slot being written this edge,
  // take it straight from wr_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (head_load) begin
      if (rd_ptr_nxt == wr_ptr)
        rd_data <= wr_data;
      else
        rd_data <= mem[rd_ptr_nxt[ADDR_WIDTH-1:0]];
    end
  end

`else

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      valid_rd <= 1'b0;
    end else begin
      valid_rd <= ra;
      if (ra) rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: table vectors plus queue model / scoreboard
// checks for sync_fifo_flags (DATA_WIDTH=8, ADDR_WIDTH=4).
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       valid_rd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] fifo_count;
  logic [4:0] af_thresh = 5'd12;
  logic [4:0] ae_thresh = 5'd3;
  logic       overflow;
  logic       underflow;
  logic       err_clr = 1'b0;

  sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data),
    .valid_rd(valid_rd),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_count(fifo_count),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] last_rd = '0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  typedef struct {
    int         reps;
    bit         wr;
    bit         rd;
    bit         clr;
    logic [4:0] aft;
    logic [4:0] aet;
    int         e_cnt;
    bit         e_af;
    bit         e_ae;
    bit         e_full;
    bit         e_empty;
    bit         e_ovf;
    bit         e_udf;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    last_rd = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_af", int'(almost_full), int'(af_thresh == 5'd0));
    chk("rst_valid", int'(valid_rd), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: update the model, drive, then check after the edge.
  task automatic step(input bit wr, input logic [7:0] wd,
                      input bit rd, input bit clr);
    bit full;
    bit empty;
    bit wa;
    bit ra;
    int cnt;
    full  = (mq.size() == 16);
    empty = (mq.size() == 0);
    wa = wr && !full;
    ra = rd && !empty;
`ifndef SYNC_FIFO_FWFT_EN
    if (ra) sb.push_back(mq[0]);
`endif
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back(wd);
    if (wr && full) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    if (rd && empty) m_udf = 1'b1;
    else if (clr)    m_udf = 1'b0;
    wr_en = wr;
    wr_data = wd;
    rd_en = rd;
    err_clr = clr;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    err_clr = 1'b0;
    cnt = mq.size();
    chk("count", int'(fifo_count), cnt);
    chk("full", int'(fifo_full), int'(cnt == 16));
    chk("empty", int'(fifo_empty), int'(cnt == 0));
    chk("almost_full", int'(almost_full), int'(cnt >= int'(af_thresh)));
    chk("almost_empty", int'(almost_empty), int'(cnt <= int'(ae_thresh)));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("valid_rd", int'(valid_rd), int'(cnt != 0));
    if (cnt != 0) chk("rd_data", int'(rd_data), int'(mq[0]));
`else
    chk("valid_rd", int'(valid_rd), int'(ra));
    if (ra) last_rd = sb.pop_front();
    chk("rd_data", int'(rd_data), int'(last_rd));
`endif
  endtask

  initial begin
    int k;
    tv[0]  = '{11, 1, 0, 0, 5'd12, 5'd3, 11, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{ 1, 1, 0, 0, 5'd12, 5'd3, 12, 1, 0, 0, 0, 0, 0};
    tv[2]  = '{ 8, 0, 1, 0, 5'd12, 5'd3,  4, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{ 1, 0, 1, 0, 5'd12, 5'd3,  3, 0, 1, 0, 0, 0, 0};
    tv[4]  = '{ 3, 0, 1, 0, 5'd12, 5'd3,  0, 0, 1, 0, 1, 0, 0};
    tv[5]  = '{ 1, 0, 1, 0, 5'd12, 5'd3,  0, 0, 1, 0, 1, 0, 1};
    tv[6]  = '{ 1, 0, 0, 1, 5'd12, 5'd3,  0, 0, 1, 0, 1, 0, 0};
    tv[7]  = '{ 1, 0, 0, 0, 5'd0,  5'd3,  0, 1, 1, 0, 1, 0, 0};
    tv[8]  = '{16, 1, 0, 0, 5'd0,  5'd16, 16, 1, 1, 1, 0, 0, 0};
    tv[9]  = '{ 1, 1, 0, 0, 5'd0,  5'd16, 16, 1, 1, 1, 0, 1, 0};
    tv[10] = '{ 1, 1, 1, 0, 5'd16, 5'd16, 15, 0, 1, 0, 0, 1, 0};
    tv[11] = '{ 1, 0, 0, 1, 5'd15, 5'd14, 15, 1, 0, 0, 0, 0, 0};
    tv[12] = '{ 1, 1, 1, 0, 5'd15, 5'd14, 15, 1, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    k = 8'h40;
    for (int i = 0; i < 13; i++) begin
      af_thresh = tv[i].aft;
      ae_thresh = tv[i].aet;
      for (int r = 0; r < tv[i].reps; r++) begin
        step(tv[i].wr, 8'(k), tv[i].rd, tv[i].clr);
        k++;
      end
      chk($sformatf("tv%0d_count", i), int'(fifo_count), tv[i].e_cnt);
      chk($sformatf("tv%0d_af", i), int'(almost_full), int'(tv[i].e_af));
      chk($sformatf("tv%0d_ae", i), int'(almost_empty), int'(tv[i].e_ae));
      chk($sformatf("tv%0d_full", i), int'(fifo_full), int'(tv[i].e_full));
      chk($sformatf("tv%0d_empty", i), int'(fifo_empty),
          int'(tv[i].e_empty));
      chk($sformatf("tv%0d_ovf", i), int'(overflow), int'(tv[i].e_ovf));
      chk($sformatf("tv%0d_udf", i), int'(underflow), int'(tv[i].e_udf));
    end

    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", int'(fifo_full), 1);
    chk("fill_count", int'(fifo_count), 16);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(fifo_count), 16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain_%0d", i), int'(rd_data), i);
    end
    chk("drain_empty", int'(fifo_empty), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", int'(underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_udf", int'(underflow), 0);

    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("both_empty_count", int'(fifo_count), 1);
    chk("both_empty_udf", int'(underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
    chk("steady_count", int'(fifo_count), 5);
    chk("steady_ovf", int'(overflow), 0);
    chk("steady_udf", int'(underflow), 0);

    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk("pre_rst_count", int'(fifo_count), 7);
    af_thresh = 5'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    af_thresh = 5'd12;

`ifdef SYNC_FIFO_FWFT_EN
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_bypass_data", int'(rd_data), 8'hA5);
    chk("fwft_bypass_valid", int'(valid_rd), 1);
`else
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_read", int'(rd_data), 8'hA5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO and successor to the basic synchronous FIFO. It adds runtime almost-full and almost-empty thresholds and sticky overflow/underflow error flags. A compile-time first-word-fall-through (FWFT) read mode is also available. It sits between a producer and a consumer in the same clock domain wherever early back-pressure or error visibility is needed.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request (pop in FWFT mode)
- rd_data  out  DATA_WIDTH  read word
- valid_rd  out  1  rd_data holds a freshly popped word (see Operation)
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count >= af_thresh
- almost_empty  out  1  count <= ae_thresh
- fifo_count  out  ADDR_WIDTH+1  number of stored words
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold, sampled continuously
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold, sampled continuously
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Write accepted (wa) = wr_en & !fifo_full. Read accepted (ra) = rd_en & !fifo_empty.
- Full blocks writes even if a read is accepted the same cycle. Empty blocks reads even if a write is accepted the same cycle.
- Storage is 2^ADDR_WIDTH words.
- wr_ptr and rd_ptr are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address memory, and the pointers wrap naturally modulo 2·DEPTH.
- fifo_count is updated as follows:
  - +1 on wa only
  - −1 on ra only
  - unchanged on wa&ra or on neither
  - never exceeds DEPTH and never underflows
- All flags are combinational from the registered fifo_count and the current threshold inputs. Comparisons are unsigned over ADDR_WIDTH+1 bits.
- Threshold edge values:
  - af_thresh=0 makes almost_full constantly 1.
  - ae_thresh ≥ DEPTH makes almost_empty constantly 1.
- overflow sets at an edge where wr_en & fifo_full. underflow sets at an edge where rd_en & fifo_empty.
  - Both hold until err_clr.
  - Set wins over a simultaneous err_clr.
  - Blocked requests change no other state.
- Reset (asynchronous assert, any time including mid-transfer):
  - Pointers and count are zeroed, so contents are logically discarded.
  - rd_data=0, valid_rd=0, overflow=0, underflow=0.
  - Hence fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(af_thresh==0).

## Timing
- Standard mode: on an ra at edge N, rd_data is loaded with the head word and valid_rd=1 for exactly the cycle after N. Otherwise valid_rd=0 and rd_data holds its last value.
- fifo_count and all flags update on the edge of the accepted operation. There is 1-cycle latency from request to flag change.
- Write-to-readable latency: a word written at edge N can be read at edge N+1.
- Throughput: one write and one read per cycle sustained, including at wrap-around.

## Configuration
- SYNC_FIFO_FWFT_EN defined → FWFT mode:
  - rd_data presents the head word whenever fifo_empty=0, and valid_rd = !fifo_empty.
  - rd_en acknowledges/pops. After an ra at edge N, the next word (if any) is on rd_data after edge N.
  - A write into an empty FIFO at edge N is visible on rd_data after edge N, via a bypass into the output register.
  - fifo_count includes the word in the output register.
  - rd_data resets to 0.
- Undefined → standard registered-read mode as described above. FWFT logic is absent.

## Test plan
- Reset then write 0x01..0x10 (16 words, ADDR_WIDTH=4) → fifo_full=1, fifo_count=16. A 17th write of 0xFF sets overflow=1 and leaves count at 16 with contents unchanged.
- Read 16 words back → rd_data 0x01..0x10 in order, each with a one-cycle valid_rd pulse (standard mode). Then fifo_empty=1. A further rd_en sets underflow=1. err_clr=1 for one cycle clears both flags.
- af_thresh=12, ae_thresh=3. Write 12 words → almost_full rises on the 12th write edge. Read 9 words → almost_empty rises when count reaches 3.
- With count=16, drive wr_en=rd_en=1 for one cycle → read accepted, write blocked, count=15, overflow=1. With count=0, drive both → write accepted, count=1, underflow=1.
- Steady simultaneous read/write for 40 cycles with count=5 → count stays 5, data order is preserved across pointer wrap, and no flags are set.
- Assert rst_n=0 asynchronously mid-stream with count=7 → outputs take reset values immediately without waiting for a clock edge. In FWFT build: a write of 0xA5 into an empty FIFO gives rd_data=0xA5 and valid_rd=1 after that edge.
